// File: rtl/snek_dir_ctrl.sv
// Snake game input front end: synchronizes and debounces four buttons, filters
// illegal turns, queues up to two of them and commits one per game frame.
module snek_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] buttons,
    input  logic       frame_tick,
    output logic [2:0] dir,
    output logic       turn_pulse,
    output logic [1:0] pending_count
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    deb;
    logic [3:0]    deb_d;
    logic [3:0]    press;
    logic [CW-1:0] cnt [4];
    logic [2:0]    queue [2];

    logic [2:0] req;
    logic [2:0] ref_dir;
    logic [2:0] opp_dir;
    logic       accept;
    logic       pop;
    logic       push;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
        end
    end

    // Per-button debounce; press is the registered rising edge of the debounced state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            deb   <= '0;
            deb_d <= '0;
            press <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            deb_d <= deb;
            press <= deb & ~deb_d;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                    deb[i] <= ~deb[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        req = 3'd0;
        if (press[0])      req = 3'd1;
        else if (press[1]) req = 3'd2;
        else if (press[2]) req = 3'd3;
        else if (press[3]) req = 3'd4;
    end

    always_comb begin
        ref_dir = dir;
        if (pending_count == 2'd2)      ref_dir = queue[1];
        else if (pending_count == 2'd1) ref_dir = queue[0];
    end

    // A stationary reference has no opposite, so every request passes.
    always_comb begin
        case (ref_dir)
            3'd1:    opp_dir = 3'd2;
            3'd2:    opp_dir = 3'd1;
            3'd3:    opp_dir = 3'd4;
            3'd4:    opp_dir = 3'd3;
            default: opp_dir = 3'd0;
        endcase
    end

    assign accept = (req != 3'd0) && (req != ref_dir) && (req != opp_dir);
    assign pop    = frame_tick && (pending_count != 2'd0);
    assign push   = accept && ((pending_count != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            queue[0]      <= 3'd0;
            queue[1]      <= 3'd0;
            dir           <= 3'd0;
            turn_pulse    <= 1'b0;
            pending_count <= 2'd0;
        end else begin
            turn_pulse <= pop;
            if (pop) begin
                dir      <= queue[0];
                queue[0] <= queue[1];
            end
            // Slot for the push is chosen from the occupancy left after any pop.
            if (push) begin
                if ((pending_count == 2'd0) || (pending_count == 2'd1 && pop)) queue[0] <= req;
                else                                                           queue[1] <= req;
            end
            if (push && !pop)      pending_count <= pending_count + 2'd1;
            else if (pop && !push) pending_count <= pending_count - 2'd1;
        end
    end
endmodule
